// File: rtl/tetris_pkg.sv
// Shared tetromino definitions: piece encodings, bag size and the draw FSM states.
package tetris_pkg;

  localparam int NUM_PIECES = 7;
  localparam int PIECE_W    = 3;

  typedef logic [NUM_PIECES-1:0] bag_mask_t;

  localparam bag_mask_t FULL_BAG = 7'h7F;

  typedef enum logic [PIECE_W-1:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_e;

  typedef enum logic [1:0] {
    ST_PRIME,
    ST_READY,
    ST_DRAW
  } bag_state_e;

  // One-hot mask bit for a piece; the unused code 7 maps to no bit.
  function automatic bag_mask_t piece_bit(logic [PIECE_W-1:0] id);
    bag_mask_t b;
    for (int k = 0; k < NUM_PIECES; k++) begin
      b[k] = (32'(id) == k);
    end
    return b;
  endfunction

endpackage

// File: rtl/piece_bag_if.sv
// Consumer-facing bundle of the piece bag: random source, request and delivered/preview piece.
interface piece_bag_if;
  import tetris_pkg::*;

  logic [7:0]         rand_in;
  logic               req;
  logic               busy;
  logic               piece_valid;
  logic [PIECE_W-1:0] piece_id;
  logic               next_valid;
  logic [PIECE_W-1:0] next_id;

  modport master (
    output rand_in, req,
    input  busy, piece_valid, piece_id, next_valid, next_id
  );

  modport slave (
    input  rand_in, req,
    output busy, piece_valid, piece_id, next_valid, next_id
  );
endinterface

// File: rtl/piece_prio_enc.sv
// Lowest-set-bit encoder over the remaining-piece mask, used for the forced draw.
module piece_prio_enc
  import tetris_pkg::*;
(
  input  bag_mask_t          mask,
  output logic [PIECE_W-1:0] lowest_idx
);

  always_comb begin
    lowest_idx = '0;
    for (int k = NUM_PIECES - 1; k >= 0; k--) begin
      if (mask[k]) lowest_idx = PIECE_W'(k);
    end
  end

endmodule

// File: rtl/piece_bag.sv
// 7-bag tetromino randomizer with a one-piece preview slot and bounded-retry draws.
module piece_bag
  import tetris_pkg::*;
#(
  parameter int MAX_REJECT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  piece_bag_if.slave  bus
);

  localparam int              REJ_W     = 4;
  localparam logic [REJ_W-1:0] REJ_LIMIT = REJ_W'(MAX_REJECT - 1);

  bag_state_e         state_q, state_d;
  bag_mask_t          mask_q, mask_d;
  logic [REJ_W-1:0]   rej_q, rej_d;
  logic               busy_q, busy_d;
  logic               piece_valid_q, piece_valid_d;
  logic [PIECE_W-1:0] piece_id_q, piece_id_d;
  logic               next_valid_q, next_valid_d;
  logic [PIECE_W-1:0] next_id_q, next_id_d;

  logic [PIECE_W-1:0] cand;
  logic [PIECE_W-1:0] lowest_idx;
  logic [PIECE_W-1:0] chosen;
  logic [NUM_PIECES:0] mask_ext;
  logic               cand_ok;
  logic               forced;
  logic               draw_accept;
  bag_mask_t          mask_cleared;

  piece_prio_enc u_prio_enc (
    .mask       (mask_q),
    .lowest_idx (lowest_idx)
  );

  // Code 7 lands on the zero pad bit, so it is rejected without a separate compare.
  assign cand         = bus.rand_in[PIECE_W-1:0];
  assign mask_ext     = {1'b0, mask_q};
  assign cand_ok      = mask_ext[cand];
  assign forced       = (rej_q == REJ_LIMIT);
  assign draw_accept  = forced || cand_ok;
  assign chosen       = forced ? lowest_idx : cand;
  assign mask_cleared = mask_q & ~piece_bit(chosen);

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    rej_d         = rej_q;
    busy_d        = busy_q;
    piece_valid_d = 1'b0;
    piece_id_d    = piece_id_q;
    next_valid_d  = next_valid_q;
    next_id_d     = next_id_q;

    unique case (state_q)
      ST_PRIME, ST_DRAW: begin
        if (draw_accept) begin
          next_id_d    = chosen;
          next_valid_d = 1'b1;
          mask_d       = (mask_cleared == '0) ? FULL_BAG : mask_cleared;
          rej_d        = '0;
          busy_d       = 1'b0;
          state_d      = ST_READY;
        end else begin
          rej_d = rej_q + 1'b1;
        end
      end
      ST_READY: begin
        if (bus.req) begin
          piece_valid_d = 1'b1;
          piece_id_d    = next_id_q;
          next_valid_d  = 1'b0;
          busy_d        = 1'b1;
          state_d       = ST_DRAW;
        end
      end
      default: begin
        state_d = ST_PRIME;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_PRIME;
      mask_q        <= FULL_BAG;
      rej_q         <= '0;
      busy_q        <= 1'b1;
      piece_valid_q <= 1'b0;
      piece_id_q    <= '0;
      next_valid_q  <= 1'b0;
      next_id_q     <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      rej_q         <= rej_d;
      busy_q        <= busy_d;
      piece_valid_q <= piece_valid_d;
      piece_id_q    <= piece_id_d;
      next_valid_q  <= next_valid_d;
      next_id_q     <= next_id_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.piece_valid = piece_valid_q;
  assign bus.piece_id    = piece_id_q;
  assign bus.next_valid  = next_valid_q;
  assign bus.next_id     = next_id_q;

endmodule

// File: doc/piece_bag.md
PIECE_BAG -- requirements
Module: piece_bag

Interface
REQ-001 Parameter MAX_REJECT, default 8: consecutive rejected draws before the deterministic fallback (range 2..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 rand_in  input  8  pseudo-random byte from the LFSR randomizer, sampled every cycle; only bits [2:0] used.
REQ-005 req  input  1  consumer request for the next tetromino; sampled at rising edge.
REQ-006 busy  output  1  high while a draw is in progress; req ignored while high.
REQ-007 piece_valid  output  1  one-cycle pulse; piece_id valid this cycle.
REQ-008 piece_id  output  3  delivered piece, encoding 0..6 (I,O,T,S,Z,J,L).
REQ-009 next_valid  output  1  preview slot holds a drawn piece.
REQ-010 next_id  output  3  preview ("next piece") value, meaningful when next_valid=1.

Function
REQ-011 Block SHALL hold a 7-bit remaining mask; bit k set = piece k not yet dealt from the current bag.
REQ-012 FSM states SHALL be PRIME, READY, DRAW; PRIME entered on reset.
REQ-013 PRIME/DRAW, each cycle: cand = rand_in[2:0]; accept iff cand != 7 and mask[cand]=1; else reject and increment reject counter.
REQ-014 On reject count reaching MAX_REJECT-1, the next draw cycle SHALL accept the lowest set mask bit regardless of rand_in (guaranteed termination, max MAX_REJECT cycles per draw).
REQ-015 On accept: next_id<=chosen, next_valid<=1, mask bit cleared, reject counter<=0, state<=READY, busy<=0, all at the same edge.
REQ-016 If clearing the bit leaves mask zero, mask SHALL reload to 7'h7F at that same edge (bag refill).
REQ-017 READY with req=1: at next edge piece_valid<=1 for exactly one cycle, piece_id<=next_id, next_valid<=0, busy<=1, state<=DRAW.
REQ-018 req=1 in PRIME or DRAW SHALL be ignored (not queued); piece_id SHALL hold its value between pulses.
REQ-019 Latency: req accepted -> piece_valid exactly 1 cycle later; new preview 1..MAX_REJECT cycles after piece_valid.
REQ-020 Every 7 consecutive accepted draws from a full mask SHALL form a permutation of 0..6.

Reset
REQ-021 rst_n=0 at an edge SHALL force: state PRIME, mask 7'h7F, reject counter 0, piece_valid 0, piece_id 0, next_valid 0, next_id 0, busy 1; overrides any simultaneous req or accept.
REQ-022 Reset mid-DRAW SHALL discard the partial bag; the first post-reset draw starts from a full mask.

Structure
REQ-023 Shared package tetris_pkg SHALL hold piece encodings, NUM_PIECES=7, FULL_BAG=7'h7F and piece_id width.
REQ-024 One sub-module SHALL be used: piece_prio_enc, combinational lowest-set-bit encoder of the mask for the fallback.
REQ-025 RTL target 120-250 lines; no memories, no multipliers.

Verification
REQ-026 Reset release, rand_in[2:0]=3 -> after 1 cycle next_valid=1, next_id=3, busy=0, mask=7'h77.
REQ-027 rand_in cycling 0..6, 7 reqs spaced by busy -> piece_id set == {0..6}, each once; mask returns to 7'h7F on 7th accept.
REQ-028 rand_in[2:0] held at 7 during DRAW with MAX_REJECT=8 -> accept on 8th draw cycle, next_id = lowest set mask bit.
REQ-029 req pulsed while busy=1 -> no piece_valid; single piece_valid for the later READY req.
REQ-030 rst_n low for 1 cycle mid-DRAW with mask 7'h0C -> all outputs at reset values, then PRIME from 7'h7F.
